// File: rtl/instr_encoder_pkg.sv
//============================================================================
// Module      : instr_encoder_pkg
// Description : Shared definitions for the instruction encoder: data width,
//               instruction field positions, format codes, FSM encodings
//               and the field-packing helper.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package instr_encoder_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;

    // Field map of the core's instruction word; the encoder is its inverse
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int DST_MSB  = 11;
    localparam int DST_LSB  = 8;
    localparam int SRC1_MSB = 7;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_MSB = 3;
    localparam int SRC2_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Instruction formats
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;

    // Load-session states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // Pack one field bundle into an instruction word. Fields that do not
    // belong to the selected format are ignored.
    function automatic logic [DATA_WIDTH-1:0] pack_instr(
        input logic       itype,
        input logic [3:0] opcode,
        input logic [3:0] dest,
        input logic [3:0] src1,
        input logic [3:0] src2,
        input logic [7:0] imm
    );
        logic [DATA_WIDTH-1:0] w_word;
        w_word = '0;
        w_word[OPC_MSB:OPC_LSB] = opcode;
        w_word[DST_MSB:DST_LSB] = dest;
        case (itype)
            FMT_I: begin
                w_word[IMM_MSB:IMM_LSB] = imm;
            end
            FMT_R: begin
                w_word[SRC1_MSB:SRC1_LSB] = src1;
                w_word[SRC2_MSB:SRC2_LSB] = src2;
            end
            default: ;
        endcase
        return w_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_fifo.sv
//============================================================================
// Module      : enc_fifo
// Description : Small synchronous FIFO buffering encoded instruction words.
//               Supports push and pop in the same cycle, including when full
//               (the pop frees the slot the push fills). DEPTH must be a
//               power of two and at least 2.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module enc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop of an empty FIFO is dropped; a push into a full FIFO is only
    // accepted when a pop frees a slot in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents are qualified by the occupancy count, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap freely
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
//============================================================================
// Module      : instr_encoder
// Description : Packs instruction field bundles (R-type or I-type) into
//               instruction words and writes them sequentially into
//               instruction memory from a base address. Encoded words are
//               buffered in enc_fifo so the memory write port can stall
//               independently of the field source.
//               Optional build macro ENC_CHECKSUM_EN adds a `checksum`
//               output: running XOR of every word written in the session.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    prog_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_itype,
    input  logic [3:0]             in_opcode,
    input  logic [3:0]             in_dest,
    input  logic [3:0]             in_src1,
    input  logic [3:0]             in_src2,
    input  logic [7:0]             in_imm,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [`DATA_WIDTH-1:0] imem_wdata,
    input  logic                   imem_wr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [`DATA_WIDTH-1:0] checksum
`endif
);

    enc_state_t r_state;
    enc_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH:0]    r_len;
    logic [ADDR_WIDTH:0]    r_accepted;
    logic [ADDR_WIDTH:0]    r_written;
    logic                   r_wrapped;
    logic                   r_overflow;

    logic                   w_start_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [`DATA_WIDTH-1:0] w_word;
    logic [`DATA_WIDTH-1:0] w_head;

    // Start is only honoured from IDLE; a start during a session is ignored
    assign w_start_ok = start && (r_state == ST_IDLE);

    // Bundle is packed combinationally and pushed on the accepting edge
    assign w_word = pack_instr(in_itype, in_opcode, in_dest, in_src1, in_src2, in_imm);
    assign w_push = in_valid && in_ready;
    assign w_pop  = imem_we && imem_wr_ready;

    // Write data is the FIFO head, forced to zero while no write is requested
    assign imem_wdata = imem_we ? w_head : '0;
    assign imem_addr  = r_addr;
    assign overflow   = r_overflow;

    enc_fifo #(
        .WIDTH (`DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, all derived from registered state
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        imem_we     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (prog_len == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = !w_full && (r_accepted < r_len);
                imem_we  = !w_empty;
                if (in_valid && in_ready && ((r_accepted + 1'b1) == r_len)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                imem_we = !w_empty;
                if ((r_written == r_len) && w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Session counters, write address and sticky wrap tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_wrapped  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_addr     <= base_addr;
            r_len      <= prog_len;
            r_accepted <= '0;
            r_written  <= '0;
            r_wrapped  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_accepted <= r_accepted + 1'b1;
            end
            if (w_pop) begin
                r_addr    <= r_addr + 1'b1;
                r_written <= r_written + 1'b1;
                // Completing a write at the top address wraps the counter
                if (&r_addr) begin
                    r_wrapped <= 1'b1;
                end
            end
            // Any write issued after the wrap marks the session as overflowed
            if (imem_we && r_wrapped) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [`DATA_WIDTH-1:0] r_checksum;

    // Running XOR of every word the memory actually accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ w_head;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. A stimulus thread runs
//               directed and randomised load sessions and queues the words
//               the memory should see; a monitor thread pops and compares
//               every write, and tracks handshakes against a simple model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_instr_encoder;

    localparam int AW    = 8;
    localparam int DW    = `DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int LIMIT = 2000;

    typedef struct packed {
        logic       itype;
        logic [3:0] op;
        logic [3:0] dst;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [7:0] imm;
    } bundle_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   prog_len;
    logic          in_valid;
    logic          in_ready;
    logic          in_itype;
    logic [3:0]    in_opcode;
    logic [3:0]    in_dest;
    logic [3:0]    in_src1;
    logic [3:0]    in_src2;
    logic [7:0]    in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          imem_wr_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef ENC_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .prog_len      (prog_len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_itype      (in_itype),
        .in_opcode     (in_opcode),
        .in_dest       (in_dest),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .in_imm        (in_imm),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_wr_ready (imem_wr_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
`ifdef ENC_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    bundle_t stim_q[$];
    wr_t     exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      wr_mode  = 0;   // 0: always ready, 1: random, 2: stalled

    // Monitor-side model of the session
    logic          m_sess  = 1'b0;
    int            m_acc   = 0;
    int            m_wr    = 0;
    int            m_len   = 0;
    logic          m_stall = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;

    // Memory-side ready pattern, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        if (wr_mode == 0)      imem_wr_ready = 1'b1;
        else if (wr_mode == 1) imem_wr_ready = ($urandom_range(0, 3) != 0);
        else                   imem_wr_ready = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the field map, using plain arithmetic
    function automatic logic [DW-1:0] model_word(input bundle_t b);
        int v;
        v = int'(b.op) * 4096 + int'(b.dst) * 256;
        if (b.itype) v = v + int'(b.imm);
        else         v = v + int'(b.s1) * 16 + int'(b.s2);
        return v[DW-1:0];
    endfunction

    function automatic bundle_t mk_r(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] a, input logic [3:0] b);
        bundle_t x;
        x.itype = 1'b0; x.op = op; x.dst = d; x.s1 = a; x.s2 = b;
        x.imm = 8'($urandom);
        return x;
    endfunction

    function automatic bundle_t mk_i(input logic [3:0] op, input logic [3:0] d, input logic [7:0] imm);
        bundle_t x;
        x.itype = 1'b1; x.op = op; x.dst = d; x.imm = imm;
        x.s1 = 4'($urandom); x.s2 = 4'($urandom);
        return x;
    endfunction

    function automatic bundle_t mk_rand();
        bundle_t x;
        x = bundle_t'({$urandom, $urandom});
        return x;
    endfunction

    task automatic drive(input bundle_t b);
        in_itype  = b.itype;
        in_opcode = b.op;
        in_dest   = b.dst;
        in_src1   = b.s1;
        in_src2   = b.s2;
        in_imm    = b.imm;
    endtask

    // Start a session and offer every bundle of stim_q; queue expected writes
    task automatic feed(input logic [AW-1:0] base, input logic [AW:0] len,
                        input bit rnd_valid, input bit glitch, output logic [DW-1:0] csum);
        int      idx;
        int      cyc;
        wr_t     e;
        idx  = 0;
        cyc  = 0;
        csum = '0;
        start = 1'b1; base_addr = base; prog_len = len;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < int'(len) && cyc < LIMIT) begin
            drive(stim_q[idx]);
            in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (glitch && idx == 1) begin
                start = 1'b1; base_addr = base ^ 8'h55; prog_len = len + 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.addr = base + idx[AW-1:0];
                e.data = model_word(stim_q[idx]);
                exp_q.push_back(e);
                csum = csum ^ e.data;
                idx++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_in_time", 32'(idx == int'(len)), 1);
    endtask

    // Wait for the done pulse and check the session-end state
    task automatic finish(input logic [AW-1:0] base, input logic [AW:0] len, input logic [DW-1:0] csum);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < LIMIT && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        check("all_written", 32'(exp_q.size()), 0);
        check("overflow", 32'(overflow), 32'((int'(base) + int'(len)) > (1 << AW)));
`ifdef ENC_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(csum));
`else
        if (csum != csum) check("csum_self", 0, 1);
`endif
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_session(input logic [AW-1:0] base, input logic [AW:0] len,
                               input bit rnd_valid, input bit glitch);
        logic [DW-1:0] csum;
        feed(base, len, rnd_valid, glitch, csum);
        finish(base, len, csum);
    endtask

    // One monitor step, at the falling edge
    task automatic monitor_cycle();
        wr_t e;
        if (!rst_n) begin
            m_sess = 1'b0; m_acc = 0; m_wr = 0; m_len = 0; m_stall = 1'b0;
            return;
        end
        check("busy", 32'(busy), 32'(m_sess));
        check("in_ready", 32'(in_ready),
              32'(m_sess && (m_acc < m_len) && ((m_acc - m_wr) < DEPTH)));
        if (done) check("done_when_complete", 32'(m_sess && (m_wr == m_len)), 1);
        if (m_stall) begin
            check("stall_we", 32'(imem_we), 1);
            check("stall_addr", 32'(imem_addr), 32'(m_addr));
            check("stall_data", 32'(imem_wdata), 32'(m_data));
        end
        if (imem_we && imem_wr_ready) begin
            check("write_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", 32'(imem_wdata), 32'(e.data));
            end
        end
        m_stall = imem_we && !imem_wr_ready;
        m_addr  = imem_addr;
        m_data  = imem_wdata;
        if (in_valid && in_ready)     m_acc++;
        if (imem_we && imem_wr_ready) m_wr++;
        if (done) m_sess = 1'b0;
        if (start && !m_sess) begin
            m_sess = 1'b1; m_acc = 0; m_wr = 0; m_len = int'(prog_len);
        end
    endtask

    initial begin
        fork
            begin : stim
                logic [DW-1:0] csum;
                rst_n = 1'b0; start = 1'b0; base_addr = '0; prog_len = '0; in_valid = 1'b0;
                drive('0);
                repeat (3) @(posedge clk);
                #1;
                check("rst_in_ready", 32'(in_ready), 0);
                check("rst_we", 32'(imem_we), 0);
                check("rst_addr", 32'(imem_addr), 0);
                check("rst_wdata", 32'(imem_wdata), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                check("rst_overflow", 32'(overflow), 0);
                rst_n = 1'b1;
                @(posedge clk); #1;

                // Basic R-type
                wr_mode = 0;
                stim_q.delete(); stim_q.push_back(mk_r(4'h1, 4'h2, 4'h3, 4'h4));
                run_session(8'h10, 9'd1, 1'b0, 1'b0);

                // I-type with don't-care sources, then R-type
                stim_q.delete();
                stim_q.push_back(mk_i(4'h5, 4'h1, 8'hAB));
                stim_q.push_back(mk_r(4'h1, 4'h2, 4'h3, 4'h4));
                run_session(8'h30, 9'd2, 1'b0, 1'b0);

                // Backpressure: memory stalled while the FIFO fills
                stim_q.delete();
                for (int k = 0; k < 6; k++) stim_q.push_back(mk_rand());
                wr_mode = 2;
                @(posedge clk); #1;
                fork
                    run_session(8'h40, 9'd6, 1'b0, 1'b0);
                    begin
                        repeat (8) @(posedge clk);
                        wr_mode = 0;
                    end
                join

                // Address wrap, then a zero-length session
                stim_q.delete();
                for (int k = 0; k < 2; k++) stim_q.push_back(mk_rand());
                run_session(8'hFF, 9'd2, 1'b0, 1'b0);
                stim_q.delete();
                run_session(8'h77, 9'd0, 1'b0, 1'b0);

                // Reset while draining with two words queued
                wr_mode = 2;
                @(posedge clk); #1;
                stim_q.delete();
                for (int k = 0; k < 2; k++) stim_q.push_back(mk_rand());
                feed(8'h20, 9'd2, 1'b0, 1'b0, csum);
                repeat (2) @(posedge clk);
                #1;
                check("pre_rst_busy", 32'(busy), 1);
                check("pre_rst_we", 32'(imem_we), 1);
                rst_n = 1'b0;
                @(posedge clk); #1;
                check("mid_rst_in_ready", 32'(in_ready), 0);
                check("mid_rst_we", 32'(imem_we), 0);
                check("mid_rst_addr", 32'(imem_addr), 0);
                check("mid_rst_wdata", 32'(imem_wdata), 0);
                check("mid_rst_busy", 32'(busy), 0);
                check("mid_rst_done", 32'(done), 0);
                check("mid_rst_overflow", 32'(overflow), 0);
`ifdef ENC_CHECKSUM_EN
                check("mid_rst_checksum", 32'(checksum), 0);
`endif
                exp_q.delete();
                rst_n = 1'b1;
                wr_mode = 0;
                repeat (2) @(posedge clk);
                #1;
                stim_q.delete(); stim_q.push_back(mk_r(4'h1, 4'h2, 4'h3, 4'h4));
                run_session(8'h10, 9'd1, 1'b0, 1'b0);

                // Start pulsed during FILL must not disturb the session
                stim_q.delete();
                for (int k = 0; k < 5; k++) stim_q.push_back(mk_rand());
                run_session(8'h80, 9'd5, 1'b1, 1'b1);

                // Randomised sessions, half of them near the top of memory
                wr_mode = 1;
                for (int s = 0; s < 16; s++) begin
                    logic [AW-1:0] b;
                    int            l;
                    b = (s % 2 == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
                    l = $urandom_range(0, 12);
                    stim_q.delete();
                    for (int k = 0; k < l; k++) stim_q.push_back(mk_rand());
                    run_session(b, 9'(l), 1'b1, 1'b0);
                end
                wr_mode = 0;
                repeat (3) @(posedge clk);
            end
            begin : mon
                forever begin
                    @(negedge clk);
                    monitor_cycle();
                end
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
